// File: rtl/inference_stream_sequencer.sv
// Streams buffered per-literal image columns as class/clause/literal beats.
// Ports: clock, reset (sync, active-high); lit_wr_en/lit_wr_addr/lit_wr_data
//   load the literal buffer while idle; run starts a pass; busy, done and
//   err_overrun report status; start_compute, input_literals, class_in and
//   clause_in carry one beat per clock. Define SEQ_PAUSE_EN to add a pause
//   input that stalls streaming.
module inference_stream_sequencer #(
  parameter int CLAUSE_LEN   = 9,
  parameter int CLASS_LEN    = 4,
  parameter int IMAGES       = 8,
  parameter int NUM_LIT      = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       lit_wr_en,
  input  logic [$clog2(NUM_LIT)-1:0] lit_wr_addr,
  input  logic [IMAGES-1:0]          lit_wr_data,
  input  logic                       run,
`ifdef SEQ_PAUSE_EN
  input  logic                       pause,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       err_overrun,
  output logic                       start_compute,
  output logic [IMAGES-1:0]          input_literals,
  output logic [CLASS_LEN-1:0]       class_in,
  output logic [CLAUSE_LEN-1:0]      clause_in
);

  localparam int LW  = (NUM_LIT > 1) ? $clog2(NUM_LIT) : 1;
  localparam int CLW = (CLAUSE_LEN > 1) ? $clog2(CLAUSE_LEN) : 1;
  localparam int CSW = (CLASS_LEN > 1) ? $clog2(CLASS_LEN) : 1;
  localparam int DW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [LW-1:0]  LIT_LAST   = LW'(NUM_LIT - 1);
  localparam logic [CLW-1:0] CL_LAST    = CLW'(CLAUSE_LEN - 1);
  localparam logic [CSW-1:0] CLS_LAST   = CSW'(CLASS_LEN - 1);
  localparam logic [DW-1:0]  DRAIN_LAST =
    DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q, state_n;

  logic [LW-1:0]  lit_q, lit_n;
  logic [CLW-1:0] cl_q, cl_n;
  logic [CSW-1:0] cls_q, cls_n;
  logic [DW-1:0]  dcnt_q, dcnt_n;

  logic                  busy_n;
  logic                  done_n;
  logic                  err_n;
  logic                  sc_n;
  logic [IMAGES-1:0]     lits_n;
  logic [CLASS_LEN-1:0]  class_n;
  logic [CLAUSE_LEN-1:0] clause_n;

  logic [IMAGES-1:0] lit_mem [NUM_LIT];
  logic              mem_we;
  logic              addr_ok;
  logic              hold;

`ifdef SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign addr_ok = 32'(lit_wr_addr) < 32'(NUM_LIT);

  // Buffer has no reset: contents survive reset and are reused by later runs.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      lit_mem[lit_wr_addr] <= lit_wr_data;
    end
  end

  always_comb begin
    state_n  = state_q;
    lit_n    = lit_q;
    cl_n     = cl_q;
    cls_n    = cls_q;
    dcnt_n   = dcnt_q;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err_overrun;
    sc_n     = 1'b0;
    lits_n   = input_literals;
    class_n  = class_in;
    clause_n = clause_in;
    mem_we   = 1'b0;

    // Any request outside IDLE is dropped and flagged.
    if (state_q != ST_IDLE && (run || lit_wr_en)) begin
      err_n = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        busy_n   = 1'b0;
        lits_n   = '0;
        class_n  = '0;
        clause_n = '0;
        // Write lands on this edge, so the first beat reads the new data.
        mem_we   = lit_wr_en && addr_ok;
        if (run) begin
          state_n = ST_STREAM;
          busy_n  = 1'b1;
          err_n   = 1'b0;
          lit_n   = '0;
          cl_n    = '0;
          cls_n   = '0;
        end
      end
      ST_STREAM: begin
        if (!hold) begin
          sc_n     = 1'b1;
          lits_n   = lit_mem[lit_q];
          class_n  = CLASS_LEN'(1) << cls_q;
          clause_n = CLAUSE_LEN'(1) << cl_q;
          if (lit_q == LIT_LAST) begin
            lit_n = '0;
            if (cl_q == CL_LAST) begin
              cl_n = '0;
              if (cls_q == CLS_LAST) begin
                cls_n   = '0;
                dcnt_n  = '0;
                state_n = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_DONE;
              end else begin
                cls_n = cls_q + 1'b1;
              end
            end else begin
              cl_n = cl_q + 1'b1;
            end
          end else begin
            lit_n = lit_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        lits_n = '0;
        if (dcnt_q == DRAIN_LAST) begin
          state_n = ST_DONE;
        end else begin
          dcnt_n = dcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_n   = 1'b1;
        busy_n   = 1'b0;
        lits_n   = '0;
        class_n  = '0;
        clause_n = '0;
        state_n  = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lit_q          <= '0;
      cl_q           <= '0;
      cls_q          <= '0;
      dcnt_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_overrun    <= 1'b0;
      start_compute  <= 1'b0;
      input_literals <= '0;
      class_in       <= '0;
      clause_in      <= '0;
    end else begin
      state_q        <= state_n;
      lit_q          <= lit_n;
      cl_q           <= cl_n;
      cls_q          <= cls_n;
      dcnt_q         <= dcnt_n;
      busy           <= busy_n;
      done           <= done_n;
      err_overrun    <= err_n;
      start_compute  <= sc_n;
      input_literals <= lits_n;
      class_in       <= class_n;
      clause_in      <= clause_n;
    end
  end

endmodule
